fwd_sel_unit: RTL and testbench
===============================

# fwd_sel_unit

Forwarding-select generator for the pipelined RISC-V core: the producer side of the 4:1 operand multiplexers in EX. It tracks the destination tags of in-flight instructions through EX, MEM, WB and one retired slot. For each ID-stage instruction it registers a 2-bit select per operand, so the operand multiplexers pick the youngest producer when that instruction is in EX. It also detects load-use hazards, requests an ID stall and inserts a bubble.

## Interface
- WIDTH_TAG, 5, register-index width
- CNT_WIDTH, 32, width of stall performance counter
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  WIDTH_TAG  source indices
- id_use_rs1, id_use_rs2  in  1  operand actually read
- id_rd  in  WIDTH_TAG  destination index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  kill ID and EX instructions (mispredict)
- mem_stall  in  1  freeze entire pipeline
- fwd_sel_a, fwd_sel_b  out  2  registered select for EX operand A/B mux
- stall_id  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  EX tag valid (not a bubble)
- stall_count  out  CNT_WIDTH  cycles with stall_id high

## Operation
- Tag pipeline: four entries EX, MEM, WB, RET, each {valid, rd, reg_write, mem_read}. A match requires valid, reg_write, rd != 0 and rd == source index.
- Select encoding, computed in ID from the current EX/MEM/WB tags:
  - 2'b01: EX tag match; the producer will be in MEM next cycle.
  - 2'b10: MEM tag match; the producer will be in WB.
  - 2'b11: WB tag match; the producer will be in RET.
  - 2'b00: no match; use the register file.
- Priority is 01 > 10 > 11 > 00, so the youngest producer wins.
- Unused operand (id_use_rsX = 0) or source x0: select 00.
- Load-use: stall_id = id_valid & id_use_rsX & EX.valid & EX.mem_read & EX.reg_write & EX.rd == rsX & rsX != 0, for either operand.
- Advance, when mem_stall = 0:
  - RET←WB, WB←MEM.
  - MEM←EX, with valid cleared if flush.
  - EX←ID fields, with valid = id_valid & !stall_id & !flush.
  - fwd_sel_* ← computed values, or 00 when the new EX entry is invalid.
- Freeze, when mem_stall = 1:
  - All tags, selects and stall_count hold.
  - flush is ignored; upstream must hold flush until mem_stall drops.
  - stall_id is still driven combinationally.
- Priority: mem_stall > flush > load-use stall. When flush = 1, stall_id is forced to 0.
- stall_count increments by 1 on each non-frozen cycle with stall_id = 1, wrapping modulo 2^CNT_WIDTH.

## Timing
- Reset (reset_n low at a clk edge): all tag valids 0, fwd_sel_a/b = 00, ex_valid = 0, stall_count = 0. stall_id is low after reset because all tags are invalid.
- Latency: selects are computed in ID cycle t and presented during cycle t+1, while the instruction is in EX. There are no combinational paths from inputs to fwd_sel_*.
- Load-use costs exactly one bubble. In cycle t+1 the load is in MEM, so the re-evaluated consumer sees a MEM match and gets select 10.
- Reset mid-operation discards all tags. The first instruction after reset gets select 00.

## Structure
- Shared package: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10, FWD_RET = 2'b11, and the tag-entry field layout.
- One sub-module, fwd_sel_match:
  - Combinational.
  - Inputs: source index, use flag, EX/MEM/WB tags.
  - Outputs: 2-bit select and load-hit flag.
  - Instantiated once per operand.

## Test plan
- Back-to-back ALU: `add x5,…` then `add x6,x5,x5` → in the second instruction's EX cycle, fwd_sel_a = fwd_sel_b = 01 and stall_id = 0.
- Distances 2 and 3: producer writes x7, consumer reads x7 two and then three instructions later → sel = 10, then 11. A fourth-distance consumer gets 00.
- Load-use: `lw x8` followed by `add x9,x8,x0` → stall_id = 1 for one cycle, ex_valid = 0 in the bubble cycle, then sel_a = 10, sel_b = 00, stall_count = 1.
- x0 and unused operands: producer with rd = 0, consumer reads x0 → sel 00. Consumer with id_use_rs2 = 0 whose rs2 matches an EX tag → sel_b = 00.
- Flush: flush during a load-use stall → stall_id = 0; next cycle ex_valid = 0 and the flushed EX entry never produces a match.
- mem_stall held 3 cycles mid-stream, plus reset_n low for one cycle during traffic:
  - During the freeze, selects and stall_count are unchanged; flush asserted in the frozen cycles has no effect.
  - After the reset, all outputs are zero.

Source files
------------

// File: rtl/fwd_sel_unit_pkg.sv
// Shared definitions for the EX operand forwarding-select logic: select codes
// and the bit layout of a tag-pipeline entry.
package fwd_sel_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_RET = 2'b11;

    // Tag entry: {rd, mem_read, reg_write, valid}, rd occupying the top bits.
    localparam int unsigned TAG_VALID = 0;
    localparam int unsigned TAG_RW    = 1;
    localparam int unsigned TAG_MR    = 2;
    localparam int unsigned TAG_RD    = 3;

    function automatic int unsigned tag_width(input int unsigned width_tag);
        return width_tag + 3;
    endfunction

endpackage

// File: rtl/fwd_sel_unit_match.sv
// Per-operand producer match: picks the youngest matching in-flight tag and
// flags a load in EX that the operand depends on.
module fwd_sel_match
    import fwd_sel_unit_pkg::*;
#(
    parameter int unsigned WIDTH_TAG = 5
) (
    input  logic [WIDTH_TAG-1:0] rs,
    input  logic                 use_rs,
    input  logic [WIDTH_TAG+2:0] ex_tag,
    input  logic [WIDTH_TAG+2:0] mem_tag,
    input  logic [WIDTH_TAG+2:0] wb_tag,
    output logic [1:0]           sel,
    output logic                 load_hit
);

    function automatic logic tag_hit(input logic [WIDTH_TAG+2:0] t,
                                     input logic [WIDTH_TAG-1:0] r);
        return t[TAG_VALID] & t[TAG_RW] & (t[TAG_RD +: WIDTH_TAG] == r);
    endfunction

    logic ex_hit, mem_hit, wb_hit;

    always_comb begin
        ex_hit   = tag_hit(ex_tag, rs);
        mem_hit  = tag_hit(mem_tag, rs);
        wb_hit   = tag_hit(wb_tag, rs);
        sel      = FWD_RF;
        load_hit = 1'b0;
        if (use_rs && (rs != '0)) begin
            if (ex_hit) begin
                sel = FWD_MEM;
            end else if (mem_hit) begin
                sel = FWD_WB;
            end else if (wb_hit) begin
                sel = FWD_RET;
            end
            load_hit = ex_hit & ex_tag[TAG_MR];
        end
    end

endmodule

// File: rtl/fwd_sel_unit.sv
// Tag pipeline (EX/MEM/WB/RET) producing registered EX forwarding selects,
// load-use stall detection with a single bubble, and a stall counter.
module fwd_sel_unit
    import fwd_sel_unit_pkg::*;
#(
    parameter int unsigned WIDTH_TAG = 5,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [WIDTH_TAG-1:0] id_rs1,
    input  logic [WIDTH_TAG-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [WIDTH_TAG-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic [1:0]           fwd_sel_a,
    output logic [1:0]           fwd_sel_b,
    output logic                 stall_id,
    output logic                 ex_valid,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int unsigned TagW = tag_width(WIDTH_TAG);

    logic [TagW-1:0]      ex_q, mem_q, wb_q, ret_q;
    logic [TagW-1:0]      id_tag, mem_d;
    logic [1:0]           sel_a_d, sel_b_d, sel_a_q, sel_b_q;
    logic                 hit_a, hit_b;
    logic [CNT_WIDTH-1:0] stall_count_q;

    fwd_sel_match #(.WIDTH_TAG(WIDTH_TAG)) u_match_a (
        .rs       (id_rs1),
        .use_rs   (id_use_rs1),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (sel_a_d),
        .load_hit (hit_a)
    );

    fwd_sel_match #(.WIDTH_TAG(WIDTH_TAG)) u_match_b (
        .rs       (id_rs2),
        .use_rs   (id_use_rs2),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (sel_b_d),
        .load_hit (hit_b)
    );

    always_comb begin
        stall_id                    = id_valid & (hit_a | hit_b) & ~flush;
        id_tag                      = '0;
        id_tag[TAG_VALID]           = id_valid & ~stall_id & ~flush;
        id_tag[TAG_RW]              = id_reg_write;
        id_tag[TAG_MR]              = id_mem_read;
        id_tag[TAG_RD +: WIDTH_TAG] = id_rd;
        mem_d                       = ex_q;
        mem_d[TAG_VALID]            = ex_q[TAG_VALID] & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ret_q         <= '0;
            sel_a_q       <= FWD_RF;
            sel_b_q       <= FWD_RF;
            stall_count_q <= '0;
        end else if (!mem_stall) begin
            ret_q   <= wb_q;
            wb_q    <= mem_q;
            mem_q   <= mem_d;
            ex_q    <= id_tag;
            // A bubble entering EX must not steer the operand muxes.
            sel_a_q <= id_tag[TAG_VALID] ? sel_a_d : FWD_RF;
            sel_b_q <= id_tag[TAG_VALID] ? sel_b_d : FWD_RF;
            if (stall_id) begin
                stall_count_q <= stall_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign fwd_sel_a   = sel_a_q;
    assign fwd_sel_b   = sel_b_q;
    assign ex_valid    = ex_q[TAG_VALID];
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed bench for fwd_sel_unit: forwarding distances, load-use bubble,
// x0/unused operands, flush, freeze and mid-stream reset.
module tb_fwd_sel_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic        flush, mem_stall;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_id, ex_valid;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_sel_unit #(.WIDTH_TAG(5), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_id     (stall_id),
        .ex_valid     (ex_valid),
        .stall_count  (stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL reset_sel_a got %b want 00", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL reset_sel_b got %b want 00", fwd_sel_b); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_count); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_id); end
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x5
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", stall_id); end
        tick();
        checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL b2b_sel_a got %b want 01", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b01) begin errors++; $display("FAIL b2b_sel_b got %b want 01", fwd_sel_b); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL b2b_ex_valid got %b want 1", ex_valid); end
        idle(4);
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL idle_sel_a got %b want 00", fwd_sel_a); end
    endtask

    task automatic test_distance();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);  // writes x7
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // filler to x0
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); // distance 2
        tick();
        checks++; if (fwd_sel_a !== 2'b10) begin errors++; $display("FAIL dist2_sel_a got %b want 10", fwd_sel_a); end
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); // distance 3
        tick();
        checks++; if (fwd_sel_a !== 2'b11) begin errors++; $display("FAIL dist3_sel_a got %b want 11", fwd_sel_a); end
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0); // distance 4
        tick();
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL dist4_sel_b got %b want 00", fwd_sel_b); end
        idle(4);
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);  // lw x8
        tick();
        set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);  // add x9,x8,x0
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall_id); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", stall_id); end
        tick();
        checks++; if (fwd_sel_a !== 2'b10) begin errors++; $display("FAIL lu_sel_a got %b want 10", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL lu_sel_b got %b want 00", fwd_sel_b); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_count); end
        idle(4);
    endtask

    task automatic test_x0_unused();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // writes x0
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);  // reads x0
        tick();
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL x0_sel_a got %b want 00", fwd_sel_a); end
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); // writes x13
        tick();
        set_id(1'b1, 5'd13, 1'b1, 5'd13, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL unused_sel_a got %b want 01", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL unused_sel_b got %b want 00", fwd_sel_b); end
        idle(4);
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1); // lw x14
        tick();
        set_id(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got %b want 1", stall_id); end
        flush = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", stall_id); end
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_ex_valid got %b want 0", ex_valid); end
        set_id(1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 5'd16, 1'b1, 1'b0);
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL fl_no_stall got %b want 0", stall_id); end
        tick();
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL fl_sel_a got %b want 00", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL fl_sel_b got %b want 00", fwd_sel_b); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL fl_count got %0d want 1", stall_count); end
        idle(4);
    endtask

    task automatic test_freeze_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0); // add x18
        tick();
        set_id(1'b1, 5'd18, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1); // lw x16,0(x18)
        tick();
        checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL fz_pre_sel_a got %b want 01", fwd_sel_a); end
        set_id(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            checks++; if (stall_id !== (i != 1)) begin errors++; $display("FAIL fz_stall[%0d] got %b want %b", i, stall_id, i != 1); end
            tick();
            checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL fz_sel_a[%0d] got %b want 01", i, fwd_sel_a); end
            checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fz_ex_valid[%0d] got %b want 1", i, ex_valid); end
            checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL fz_count[%0d] got %0d want 1", i, stall_count); end
        end
        flush = 1'b0;
        mem_stall = 1'b0;
        #1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fz_bubble got %b want 0", ex_valid); end
        checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL fz_count2 got %0d want 2", stall_count); end
        tick();
        checks++; if (fwd_sel_a !== 2'b10) begin errors++; $display("FAIL fz_post_sel_a got %b want 10", fwd_sel_a); end
        reset_n = 1'b0;
        tick();
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL rst_sel_a got %b want 00", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL rst_sel_b got %b want 00", fwd_sel_b); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %b want 0", ex_valid); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", stall_count); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_id); end
        reset_n = 1'b1;
        #1;
        tick();
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL rst_first_sel got %b want 00", fwd_sel_a); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %b want 1", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_freeze_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
